// File: rtl/mem_req_initiator.sv
// Initiator side of the single-port memory request protocol: turns upstream
// commands into write_en/read_en strobes and returns read data or a timeout.
module mem_req_initiator #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int TIMEOUT       = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_timeout,
    output logic                     write_en,
    output logic                     read_en,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_out,
    input  logic [DATA_WIDTH-1:0]    data_out,
    output logic [CNT_WIDTH-1:0]     wr_cnt,
    output logic [CNT_WIDTH-1:0]     rd_cnt,
    output logic [CNT_WIDTH-1:0]     to_cnt,
    output logic [CNT_WIDTH-1:0]     spur_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Value of the wait counter at the start of the final permitted WAIT_RD cycle
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     is_write_q, is_write_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]    data_in_q, data_in_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_timeout_q, rsp_timeout_d;
    logic [CNT_WIDTH-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]     to_cnt_q, to_cnt_d;
    logic [CNT_WIDTH-1:0]     spur_cnt_q, spur_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Next-state and next-register computation for the whole initiator
    always_comb begin
        state_d       = state_q;
        is_write_d    = is_write_q;
        address_d     = address_q;
        data_in_d     = data_in_q;
        tmo_d         = tmo_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        to_cnt_d      = to_cnt_q;
        spur_cnt_d    = spur_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    is_write_d = cmd_write;
                    address_d  = cmd_addr;
                    // Reads leave the write-data pins untouched
                    if (cmd_write) begin
                        data_in_d = cmd_wdata;
                    end else begin
                        data_in_d = data_in_q;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (is_write_q) begin
                    wr_cnt_d = sat_inc(wr_cnt_q);
                    state_d  = IDLE;
                end else begin
                    tmo_d   = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // Data arriving in the last allowed cycle still wins over the timeout
                if (valid_out) begin
                    rsp_rdata_d   = data_out;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    to_cnt_d      = sat_inc(to_cnt_q);
                    state_d       = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rd_cnt_d = sat_inc(rd_cnt_q);
                    state_d  = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (valid_out && (state_q != WAIT_RD)) begin
            spur_cnt_d = sat_inc(spur_cnt_q);
        end else begin
            spur_cnt_d = spur_cnt_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            is_write_q    <= 1'b0;
            address_q     <= '0;
            data_in_q     <= '0;
            tmo_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            to_cnt_q      <= '0;
            spur_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            address_q     <= address_d;
            data_in_q     <= data_in_d;
            tmo_q         <= tmo_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            to_cnt_q      <= to_cnt_d;
            spur_cnt_q    <= spur_cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign write_en    = (state_q == ISSUE) && is_write_q;
    assign read_en     = (state_q == ISSUE) && !is_write_q;
    assign address     = address_q;
    assign data_in     = data_in_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;
    assign to_cnt      = to_cnt_q;
    assign spur_cnt    = spur_cnt_q;

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Initiator end of the single-port memory request protocol: converts upstream commands into write_en/read_en/address/data_in transactions and collects valid_out/data_out read returns.
- Drives the memory DUT pins directly; serves as the RTL counterpart for loopback and system-level tests of the memory block.
- One transaction outstanding at a time.
- Per-read timeout, plus saturating status counters.

Parameters:
- DATA_WIDTH, 32, width of write data and read return data.
- ADDRESS_WIDTH, 4, memory address width.
- TIMEOUT, 16, max cycles in WAIT_RD before a read is abandoned (≥1).
- CNT_WIDTH, 16, width of each status counter.

Ports:
- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  upstream command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  upstream accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 on timeout.
- rsp_timeout  out  1  response is a timeout, not real data.
- write_en  out  1  memory write strobe.
- read_en  out  1  memory read strobe.
- address  out  ADDRESS_WIDTH  memory address.
- data_in  out  DATA_WIDTH  memory write data.
- valid_out  in  1  memory read data valid.
- data_out  in  DATA_WIDTH  memory read data.
- wr_cnt, rd_cnt, to_cnt, spur_cnt  out  CNT_WIDTH each  completed writes, completed reads (incl. timeouts), timeouts, spurious valid_out.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst high at posedge):
  - State goes to IDLE.
  - All outputs go to 0, including the counters and the address/data_in registers.
  - Exception: cmd_ready reads 1 from the first cycle after reset deasserts.
  - rst overrides everything, including mid-transaction. Any in-flight command or response is dropped with no response, and no counter increments for it.
- States: IDLE, ISSUE, WAIT_RD, RESP. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - cmd_ready = 1 (combinational on state).
  - On cmd_valid && cmd_ready at edge N: latch cmd_write/addr/wdata, load address and data_in registers, go to ISSUE.
- ISSUE (cycle N+1):
  - Exactly one of write_en/read_en is high for exactly one cycle.
  - address/data_in are valid this cycle and hold their value until the next command is accepted.
  - data_in is driven only from write commands; it keeps its previous value on reads.
  - Write: go to IDLE, wr_cnt++. cmd_ready is high again in cycle N+2, so back-to-back writes issue every 2 cycles.
  - Read: go to WAIT_RD, clear the timeout counter.
- WAIT_RD:
  - Timeout counter increments each cycle spent here.
  - valid_out high: capture data_out into rsp_rdata, rsp_timeout = 0, go to RESP.
  - Counter reaches TIMEOUT with no valid_out: rsp_rdata = 0, rsp_timeout = 1, to_cnt++, go to RESP.
  - valid_out is checked before the timeout, so valid_out in the same cycle as the timeout is treated as success.
  - Minimum read latency seen upstream: valid_out in N+2 gives rsp_valid in N+3.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_timeout held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rd_cnt++, go to IDLE.
  - rsp_valid drops the following cycle.
- Spurious valid_out: valid_out high in any state other than WAIT_RD increments spur_cnt and is otherwise ignored. This includes a valid_out arriving after a timeout.
- cmd_valid while not in IDLE: not accepted (cmd_ready = 0); upstream must hold the command.
- Counters: saturate at all-ones and never wrap.

Test Plan:
- Write 0xDEADBEEF to addr 0x3 from IDLE (accepted edge N) -> write_en=1, address=0x3, data_in=0xDEADBEEF only in cycle N+1; cmd_ready=1 in N+2; wr_cnt=1.
- Read addr 0x3 with memory model returning data_out=0xDEADBEEF and valid_out 1 cycle after read_en, rsp_ready=1 -> rsp_valid in the cycle after valid_out, rsp_rdata=0xDEADBEEF, rsp_timeout=0, rd_cnt=1.
- Read with no valid_out, TIMEOUT=16 -> rsp_valid with rsp_timeout=1, rsp_rdata=0, to_cnt=1, rd_cnt=1. A late valid_out then gives spur_cnt=1 and no second response.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable all 5 cycles, cmd_ready=0, new cmd_valid not accepted; completes on the first rsp_ready=1 cycle.
- rst asserted for 1 cycle during WAIT_RD -> next cycle: all outputs 0, no response ever emitted, counters 0; the next read completes normally.
- 5 back-to-back writes with cmd_valid held high -> write_en pulses every 2 cycles, addresses in order, wr_cnt=5. With CNT_WIDTH=2, wr_cnt saturates at 3.
